// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM: Moore decode of the registered state, with IRWrite/PCWrite qualified by mem_ready in FETCH.
// Optional ILLEGAL_OP_TRAP_EN adds a sticky TRAP state and the illegal output for unrecognised opcodes.
module multicycle_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       PCSource,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic [1:0] ALUOp,
    output logic [1:0] ALUSrcB,
    output logic [3:0] state
`ifdef ILLEGAL_OP_TRAP_EN
    ,
    output logic       illegal
`endif
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_RTYP = 7'b0110011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    typedef enum logic [3:0] {
        RST    = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        MEMADR = 4'd3,
        MEMRD  = 4'd4,
        MEMWB  = 4'd5,
        MEMWR  = 4'd6,
        EXEC   = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
`ifdef ILLEGAL_OP_TRAP_EN
        ,
        TRAP   = 4'd10
`endif
    } state_t;

    typedef struct packed {
        logic       fetch;
        logic       pc_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       pc_source;
        logic       src_a;
        logic       reg_write;
        logic [1:0] alu_op;
        logic [1:0] src_b;
`ifdef ILLEGAL_OP_TRAP_EN
        logic       trap;
`endif
    } ctrl_t;

    state_t     st_q;
    state_t     nxt;
    ctrl_t      ctrl_q;
    logic [6:0] op_q;

    function automatic state_t next_of(state_t s, logic [6:0] op, logic [6:0] op_l, logic rdy);
        state_t n;
        n = FETCH;
        case (s)
            RST:    n = FETCH;
            FETCH:  n = rdy ? DECODE : FETCH;
            DECODE: begin
                if (op == OP_LW || op == OP_SW) n = MEMADR;
                else if (op == OP_RTYP)         n = EXEC;
                else if (op == OP_BEQ)          n = BRANCH;
`ifdef ILLEGAL_OP_TRAP_EN
                else                            n = TRAP;
`else
                else                            n = FETCH;
`endif
            end
            // Live opcode may have moved on; the lw/sw split uses the copy taken in DECODE
            MEMADR: n = (op_l == OP_LW) ? MEMRD : MEMWR;
            MEMRD:  n = rdy ? MEMWB : MEMRD;
            MEMWB:  n = FETCH;
            MEMWR:  n = rdy ? FETCH : MEMWR;
            EXEC:   n = ALUWB;
            ALUWB:  n = FETCH;
            BRANCH: n = FETCH;
`ifdef ILLEGAL_OP_TRAP_EN
            TRAP:   n = TRAP;
`endif
            default: n = FETCH;
        endcase
        return n;
    endfunction

    function automatic ctrl_t ctrl_of(state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.fetch    = 1'b1;
                c.mem_read = 1'b1;
                c.src_b    = 2'b01;
            end
            DECODE: c.src_b = 2'b11;
            MEMADR: begin
                c.src_a = 1'b1;
                c.src_b = 2'b10;
            end
            MEMRD: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            MEMWR: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            EXEC: begin
                c.src_a  = 1'b1;
                c.alu_op = 2'b10;
            end
            ALUWB: c.reg_write = 1'b1;
            BRANCH: begin
                c.src_a     = 1'b1;
                c.alu_op    = 2'b01;
                c.pc_cond   = 1'b1;
                c.pc_source = 1'b1;
            end
`ifdef ILLEGAL_OP_TRAP_EN
            TRAP: c.trap = 1'b1;
`endif
            default: c = '0;
        endcase
        return c;
    endfunction

    assign nxt = next_of(st_q, opcode, op_q, mem_ready);

    // Outputs are registered from the state being entered, so they line up with st_q
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= RST;
            op_q   <= '0;
            ctrl_q <= '0;
        end else begin
            st_q   <= nxt;
            ctrl_q <= ctrl_of(nxt);
            if (st_q == DECODE) op_q <= opcode;
        end
    end

    assign state       = st_q;
    assign PCWrite     = ctrl_q.fetch & mem_ready;
    assign IRWrite     = ctrl_q.fetch & mem_ready;
    assign PCWriteCond = ctrl_q.pc_cond;
    assign IorD        = ctrl_q.iord;
    assign MemRead     = ctrl_q.mem_read;
    assign MemWrite    = ctrl_q.mem_write;
    assign MemtoReg    = ctrl_q.mem_to_reg;
    assign PCSource    = ctrl_q.pc_source;
    assign ALUSrcA     = ctrl_q.src_a;
    assign RegWrite    = ctrl_q.reg_write;
    assign ALUOp       = ctrl_q.alu_op;
    assign ALUSrcB     = ctrl_q.src_b;
`ifdef ILLEGAL_OP_TRAP_EN
    assign illegal     = ctrl_q.trap;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: an instruction-level model pushes the expected per-cycle
// state/outputs, and a negedge monitor pops and compares them.
module tb_multicycle_control;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_RTYP = 7'b0110011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = '0;
    logic       mem_ready = 1'b0;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, PCSource, ALUSrcA, RegWrite;
    logic [1:0] ALUOp, ALUSrcB;
    logic [3:0] state;
    logic       ill_w;

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .PCSource(PCSource),
        .ALUSrcA(ALUSrcA), .RegWrite(RegWrite), .ALUOp(ALUOp), .ALUSrcB(ALUSrcB),
        .state(state)
`ifdef ILLEGAL_OP_TRAP_EN
        , .illegal(ill_w)
`endif
    );

`ifndef ILLEGAL_OP_TRAP_EN
    assign ill_w = 1'b0;
`endif

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [18:0] exp_q[$];
    logic [3:0]  plan[$];
    logic [6:0]  cur_op;
    int          fetch_stall, mem_stall;
    logic [18:0] act, e;

    assign act = {state, ill_w, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                  MemtoReg, PCSource, ALUSrcA, RegWrite, ALUOp, ALUSrcB};

    // Expected {state, illegal, PCWrite..RegWrite, ALUOp, ALUSrcB} for one cycle in a given phase
    function automatic logic [18:0] exp_of(logic [3:0] ph, logic rdy);
        logic pcw, pcc, iord, mr, mw, irw, m2r, pcs, sa, rw, ill;
        logic [1:0] aop, sb;
        {pcw, pcc, iord, mr, mw, irw, m2r, pcs, sa, rw, ill} = '0;
        aop = 2'b00;
        sb  = 2'b00;
        case (ph)
            4'd1:  begin mr = 1; sb = 2'b01; pcw = rdy; irw = rdy; end
            4'd2:  sb = 2'b11;
            4'd3:  begin sa = 1; sb = 2'b10; end
            4'd4:  begin mr = 1; iord = 1; end
            4'd5:  begin rw = 1; m2r = 1; end
            4'd6:  begin mw = 1; iord = 1; end
            4'd7:  begin sa = 1; aop = 2'b10; end
            4'd8:  rw = 1;
            4'd9:  begin sa = 1; aop = 2'b01; pcc = 1; pcs = 1; end
            4'd10: ill = 1;
            default: ;
        endcase
        return {ph, ill, pcw, pcc, iord, mr, mw, irw, m2r, pcs, sa, rw, aop, sb};
    endfunction

    function automatic logic known(logic [6:0] op);
        return op == OP_LW || op == OP_SW || op == OP_RTYP || op == OP_BEQ;
    endfunction

    // Phase list for one instruction: fetch, decode, then the class-specific tail
    task automatic new_instr(input logic [6:0] op, input int fs, input int ms);
        cur_op = op;
        fetch_stall = fs;
        mem_stall = ms;
        plan.push_back(4'd1);
        plan.push_back(4'd2);
        if (op == OP_LW) begin
            plan.push_back(4'd3); plan.push_back(4'd4); plan.push_back(4'd5);
        end else if (op == OP_SW) begin
            plan.push_back(4'd3); plan.push_back(4'd6);
        end else if (op == OP_RTYP) begin
            plan.push_back(4'd7); plan.push_back(4'd8);
        end else if (op == OP_BEQ) begin
            plan.push_back(4'd9);
        end else begin
`ifdef ILLEGAL_OP_TRAP_EN
            for (int i = 0; i < 4; i++) plan.push_back(4'd10);
`endif
        end
    endtask

    task automatic step();
        logic [3:0] ph;
        logic rdy;
        ph = plan[0];
        if (ph == 4'd1) begin
            rdy = (fetch_stall == 0);
            if (!rdy) fetch_stall--;
        end else if (ph == 4'd4 || ph == 4'd6) begin
            rdy = (mem_stall == 0);
            if (!rdy) mem_stall--;
        end else begin
            rdy = 1'($urandom_range(0, 1));
        end
        mem_ready = rdy;
        opcode = (ph == 4'd2) ? cur_op : 7'($urandom);
        exp_q.push_back(exp_of(ph, rdy));
        if (!((ph == 4'd1 || ph == 4'd4 || ph == 4'd6) && !rdy)) void'(plan.pop_front());
    endtask

    task automatic run_instr(input logic [6:0] op, input int fs, input int ms);
        new_instr(op, fs, ms);
        while (plan.size() > 0) begin
            @(posedge clk); #1;
            step();
        end
    endtask

    task automatic reset_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            rst_n = 1'b0;
            exp_q.push_back(exp_of(4'd0, 1'b0));
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.push_back(exp_of(4'd0, 1'b0));
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL cycle t=%0t {state,ill,ctl} act=%h exp=%h", $time, act, e);
            end
        end
    end

    initial begin
        logic [6:0] op;
        int sel;
        reset_cycles(2);
        // Directed: R-type with two fetch stalls, lw with three MEMRD stalls, sw, beq
        run_instr(OP_RTYP, 2, 0);
        run_instr(OP_LW, 0, 3);
        run_instr(OP_SW, 0, 0);
        run_instr(OP_BEQ, 0, 0);
        for (int n = 0; n < 150; n++) begin
`ifdef ILLEGAL_OP_TRAP_EN
            sel = int'($urandom_range(0, 3));
`else
            sel = int'($urandom_range(0, 4));
`endif
            case (sel)
                0: op = OP_LW;
                1: op = OP_SW;
                2: op = OP_RTYP;
                3: op = OP_BEQ;
                default: begin
                    op = 7'($urandom);
                    while (known(op)) op = 7'($urandom);
                end
            endcase
            run_instr(op, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
        end
        // Asynchronous reset asserted mid-cycle during a stalled MEMRD
        new_instr(OP_LW, 0, 5);
        while (plan[0] != 4'd4) begin
            @(posedge clk); #1;
            step();
        end
        @(posedge clk); #1;
        mem_ready = 1'b0;
        #2 rst_n = 1'b0;
        exp_q.push_back(exp_of(4'd0, 1'b0));
        plan.delete();
        reset_cycles(1);
        // Unrecognised opcode: nop back to FETCH, or sticky TRAP until reset
        run_instr(7'b1111111, 0, 0);
        run_instr(OP_RTYP, 0, 0);
        reset_cycles(1);
        @(negedge clk); #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
